display_arbiter: RTL
====================

// Module: display_arbiter
// PURPOSE
//  Shares the 4-digit 7-segment display between three message sources:
//  score (0), win (1) and loss (2).
//  - Arbitrates by fixed priority, loss > win > score.
//  - Enforces a minimum hold time once a source is granted.
//  - Drives the multiplexed seg/an scan from a built-in prescaler.
//  Sits between the game FSM / message generators and the board display pins.
//  Display patterns are active-low: seg bit 0 = segment on.
// PARAMETERS
//  DIV          100000  clk cycles per digit slot; >=2; counter width $clog2(DIV)
//  HOLD_ROUNDS  250     minimum full scan rounds a granted source is shown; >=1
// PORTS
//  clk          in   1   system clock; one clock domain, all logic on posedge clk
//  rst          in   1   synchronous, active-high reset
//  req          in   3   request per source; bit2 = loss, bit1 = win, bit0 = score
//  frame0       in   28  score pattern; [27:21] = digit0 (leftmost) ... [6:0] = digit3
//  frame1       in   28  win pattern, same layout as frame0
//  frame2       in   28  loss pattern, same layout as frame0
//  seg          out  7   segment drive, active-low
//  an           out  4   anode drive, active-low one-hot
//  grant        out  3   one-hot granted source; 000 when idle
//  round_start  out  1   one-cycle pulse on the edge a new scan round begins
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - div_cnt=0, digit=0, state=IDLE, grant=000, hold_cnt=0
//   - snap=28'hFFFFFFF, seg=7'b1111111, an=4'b1111, round_start=0
//  Prescaler:
//   - div_cnt counts 0..DIV-1 and wraps; tick = (div_cnt==DIV-1)
//   - Free-running in every state
//  Digit scan:
//   - On tick, digit advances 0->1->2->3->0
//   - boundary = tick && digit==3; round_start is registered high for exactly that edge
//   - First boundary after reset is at cycle 4*DIV
//  Outputs:
//   - seg and an are registered and load on the same edge that digit changes
//   - SHOW: an = 0111/1011/1101/1110 for digit 0/1/2/3; seg = snap[27-7*digit -: 7]
//   - IDLE: seg=7'b1111111, an=4'b1111
//  Snapshot:
//   - At each boundary, snap <= frame of the grant selected at that edge
//   - The digit-0 seg loaded on that same edge comes from that frame directly
//   - Frame input changes mid-round do not appear until the next round (no tearing)
//  State machine (updates only at boundary; between boundaries grant is frozen):
//   - IDLE:
//     - req==000: stay IDLE
//     - otherwise: go to SHOW, grant = highest-priority req bit, hold_cnt = HOLD_ROUNDS-1
//   - SHOW with hold_cnt>0:
//     - hold_cnt--; grant unchanged, even if its req dropped or a higher req rose
//   - SHOW with hold_cnt==0, re-arbitrate:
//     - req==000: go to IDLE, grant=000
//     - winner == current grant: stay, hold_cnt stays 0
//     - winner != current grant: grant=winner, hold_cnt = HOLD_ROUNDS-1
//  Simultaneous events:
//   - Several req bits high -> the higher index wins
//   - A req pulse that falls before the boundary is not seen
//   - rst has priority over tick and boundary
//  Reset mid-round: outputs blank on the next edge; the scan restarts at digit 0.
// TESTING (DIV=4, HOLD_ROUNDS=2)
//  1. rst then req=000 for 40 cycles
//     -> seg=7F, an=F, grant=000 throughout
//     -> round_start pulses at cycles 16 and 32
//  2. req=001, frame0=28'h0000001 set before cycle 16
//     -> from the edge at cycle 16: grant=001, seg=7'h00, an=0111
//     -> an steps 1011/1101/1110 every 4 cycles; digit3 seg=7'h01
//  3. grant=001, hold expired; req=101 raised at digit 1
//     -> grant stays 001 to the end of the round, then 100 at the boundary
//  4. req=100 granted, dropped after 1 cycle
//     -> loss frame shown for exactly 2 rounds (32 cycles), then blank with grant=000
//  5. frame0 changed while digit==1
//     -> digits 2,3 of this round show the old pattern; the next round shows the new one
//  6. rst pulsed during SHOW at digit 2
//     -> next edge: seg=7F, an=F, grant=000
//     -> next round_start 16 cycles after rst deasserts

Source files
------------

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - fixed-priority arbiter driving a 4-digit multiplexed 7-segment display
//
// Purpose:
//   Shares one 4-digit active-low 7-segment display between three message
//   sources: score (0), win (1) and loss (2). Priority is fixed: loss > win > score.
//   A granted source is shown for at least HOLD_ROUNDS full scan rounds.
//   The frame of the granted source is captured once per round, so a round never
//   mixes digits from two different frames.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   req[2:0]     per-source request (2 = loss, 1 = win, 0 = score)
//   frame0..2    28-bit patterns, [27:21] = leftmost digit ... [6:0] = rightmost
//   seg[6:0]     segment drive, active-low
//   an[3:0]      anode drive, active-low one-hot
//   grant[2:0]   one-hot granted source, 000 when idle
//   round_start  one-cycle pulse on the edge a new scan round begins

module display_arbiter #(
  parameter int DIV         = 100000,
  parameter int HOLD_ROUNDS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [27:0] frame0,
  input  logic [27:0] frame1,
  input  logic [27:0] frame2,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [2:0]  grant,
  output logic        round_start
);

  localparam int CW = $clog2(DIV);
  localparam int HW = (HOLD_ROUNDS > 1) ? $clog2(HOLD_ROUNDS) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_ROUNDS - 1);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [2:0]  grant_q, grant_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [27:0] snap_q, snap_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        round_start_q, round_start_d;

  logic        tick;
  logic        boundary;
  logic [2:0]  winner;
  logic [27:0] sel_frame;

  always_comb begin
    tick     = (div_cnt_q == DIV_LAST);
    boundary = tick && (digit_q == 2'd3);

    winner = 3'b000;
    if (req[2])      winner = 3'b100;
    else if (req[1]) winner = 3'b010;
    else if (req[0]) winner = 3'b001;

    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;

    // Arbitration decisions are only taken at the round boundary; grant is
    // frozen for the whole round in between.
    if (boundary) begin
      case (state_q)
        IDLE: begin
          if (req != 3'b000) begin
            state_d = SHOW;
            grant_d = winner;
            hold_d  = HOLD_INIT;
          end
        end
        SHOW: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
          end else if (req == 3'b000) begin
            state_d = IDLE;
            grant_d = 3'b000;
            hold_d  = '0;
          end else if (winner != grant_q) begin
            grant_d = winner;
            hold_d  = HOLD_INIT;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = 3'b000;
          hold_d  = '0;
        end
      endcase
    end

    case (grant_d)
      3'b001:  sel_frame = frame0;
      3'b010:  sel_frame = frame1;
      3'b100:  sel_frame = frame2;
      default: sel_frame = 28'hFFFFFFF;
    endcase

    // snap_d already holds the new frame at a boundary, so digit 0 of the new
    // round comes straight from the freshly selected source.
    snap_d        = boundary ? sel_frame : snap_q;
    div_cnt_d     = tick ? '0 : div_cnt_q + CW'(1);
    digit_d       = tick ? digit_q + 2'd1 : digit_q;
    round_start_d = boundary;

    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      if (state_d == SHOW) begin
        case (digit_d)
          2'd0: begin an_d = 4'b0111; seg_d = snap_d[27:21]; end
          2'd1: begin an_d = 4'b1011; seg_d = snap_d[20:14]; end
          2'd2: begin an_d = 4'b1101; seg_d = snap_d[13:7];  end
          default: begin an_d = 4'b1110; seg_d = snap_d[6:0]; end
        endcase
      end else begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      digit_q       <= 2'd0;
      grant_q       <= 3'b000;
      hold_q        <= '0;
      snap_q        <= 28'hFFFFFFF;
      seg_q         <= 7'b1111111;
      an_q          <= 4'b1111;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      digit_q       <= digit_d;
      grant_q       <= grant_d;
      hold_q        <= hold_d;
      snap_q        <= snap_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      round_start_q <= round_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign grant       = grant_q;
  assign round_start = round_start_q;

endmodule
